act_deriv_pipe: RTL and testbench

Multi-lane, streaming activation-derivative unit for the backpropagation path of the floating-point neural network. It computes one of four IEEE-754 single-precision activation derivatives per lane, using a fixed-latency chain of the team's Fadder, Fmultiplier and Fdivider units. A valid/ready handshake on both sides and an output FIFO with credit-based admission let the downstream gradient multiplier stall without losing results.

---
 rtl/act_deriv_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_act_deriv_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/act_deriv_pipe.sv
// act_deriv_pipe: multi-lane streaming activation-derivative unit.
// Per lane it computes y = 1 / (k * (1 + |x|)^2) for the softsign-family
// modes and a step constant for the ReLU-family modes. The result goes into
// an output FIFO. Admission is credit based, so the arithmetic pipeline
// never stalls.
// Optional feature macro: ACT_DERIV_LEAKY_EN (mode 2 returns alpha = 0.01
// for non-positive inputs; without it, mode 2 behaves like mode 1).
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds valid and its data until that edge. ready never depends
// combinationally on valid. in_ready depends only on registered state and reset.

// Fixed-latency register chain. It models the register stages of the Fp units.
module act_deriv_delay #(
  parameter int W = 32,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] pipe [D];

  // Shift data one stage per cycle; clear all stages on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < D; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[D-1];
endmodule

module act_deriv_pipe #(
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADD_LAT    = 2,
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [32*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_data,
  output logic                  busy
);
  localparam int L  = ADD_LAT + 2*MUL_LAT + DIV_LAT;
  localparam int DW = 32*LANES;
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] ONE = 32'h3F800000;
  localparam logic [31:0] TWO = 32'h40000000;
  localparam logic [49:0] RECIP_NUM = 50'd1 << 49;

  // Round a 24-bit significand (hidden bit at bit 23) using the next lower bit.
  function automatic logic [31:0] fp_pack(input logic [7:0] e, input logic [23:0] m,
                                          input logic rb);
    logic [24:0] mr;
    mr = {1'b0, m} + {24'd0, rb};
    if (mr[24]) return {1'b0, e + 8'd1, mr[23:1]};
    return {1'b0, e, mr[22:0]};
  endfunction

  // Sum of two non-negative normals; a zero or denormal operand counts as zero.
  function automatic logic [31:0] fp_add_pos(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi, lo;
    logic [7:0]  e, ed;
    logic [47:0] mh, ml;
    logic [48:0] sum;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:23] >= b[30:23]) begin hi = a; lo = b; end
    else begin hi = b; lo = a; end
    e   = hi[30:23];
    ed  = hi[30:23] - lo[30:23];
    mh  = {1'b1, hi[22:0], 24'd0};
    ml  = {1'b1, lo[22:0], 24'd0} >> ed;
    sum = {1'b0, mh} + {1'b0, ml};
    if (sum[48]) return fp_pack(e + 8'd1, sum[48:25], sum[24]);
    return fp_pack(e, sum[47:24], sum[23]);
  endfunction

  // Product of two non-negative normals.
  function automatic logic [31:0] fp_mul_pos(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = a[30:23] + b[30:23] - 8'd127;
    if (p[47]) return fp_pack(e + 8'd1, p[47:24], p[23]);
    return fp_pack(e, p[46:23], p[22]);
  endfunction

  // 1.0 / f for a positive normal f.
  function automatic logic [31:0] fp_recip(input logic [31:0] f);
    logic [49:0] q;
    if (f[30:23] == 8'd0) return 32'd0;
    if (f[22:0] == 23'd0) return {1'b0, 8'd254 - f[30:23], 23'd0};
    q = RECIP_NUM / {26'd0, 1'b1, f[22:0]};
    return fp_pack(8'd253 - f[30:23], q[25:2], q[1]);
  endfunction

  logic            reset_n, accept, pop;
  logic [31:0]     k_in, k_d, neg_val;
  logic [DW-1:0]   div_out, const_in, tail_const, tail_data, wr_data;
  logic [1:0]      tail_mode;
  logic [DW+1:0]   ctl_q;
  logic [L-1:0]    ctl_valid;
  logic            wr_valid;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW-1:0]   total;
  logic [DW-1:0]   mem [FIFO_DEPTH];

  assign reset_n = ~reset;
  assign accept  = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign k_in    = (in_mode == 2'd3) ? ONE : TWO;

`ifdef ACT_DERIV_LEAKY_EN
  localparam logic [31:0] ALPHA = 32'h3C23D70A;
  assign neg_val = (in_mode == 2'd2) ? ALPHA : 32'd0;
`else
  assign neg_val = 32'd0;
`endif

  // The scale k joins the chain at the second multiply.
  act_deriv_delay #(.W(32), .D(ADD_LAT + MUL_LAT)) u_k (
    .clk(clk), .reset_n(reset_n), .d(k_in), .q(k_d));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] x, a, s_c, s, q_c, q, f_c, f, y_c, y;
    assign x   = in_data[32*i +: 32];
    assign a   = {1'b0, x[30:0]};
    assign s_c = fp_add_pos(ONE, a);
    act_deriv_delay #(.W(32), .D(ADD_LAT)) u_add (
      .clk(clk), .reset_n(reset_n), .d(s_c), .q(s));
    assign q_c = fp_mul_pos(s, s);
    act_deriv_delay #(.W(32), .D(MUL_LAT)) u_sq (
      .clk(clk), .reset_n(reset_n), .d(q_c), .q(q));
    assign f_c = fp_mul_pos(q, k_d);
    act_deriv_delay #(.W(32), .D(MUL_LAT)) u_scale (
      .clk(clk), .reset_n(reset_n), .d(f_c), .q(f));
    assign y_c = fp_recip(f);
    act_deriv_delay #(.W(32), .D(DIV_LAT)) u_div (
      .clk(clk), .reset_n(reset_n), .d(y_c), .q(y));
    assign div_out[32*i +: 32]  = y;
    // Step-function result is decided at input: positive non-zero gives 1.0.
    assign const_in[32*i +: 32] = (!x[31] && (x[30:0] != 31'd0)) ? ONE : neg_val;
  end

  // Mode and step constants travel alongside the arithmetic chain.
  act_deriv_delay #(.W(DW + 2), .D(L)) u_ctl (
    .clk(clk), .reset_n(reset_n), .d({in_mode, const_in}), .q(ctl_q));
  assign tail_mode  = ctl_q[DW+1:DW];
  assign tail_const = ctl_q[DW-1:0];
  assign tail_data  = (tail_mode == 2'd0 || tail_mode == 2'd3) ? div_out : tail_const;

  // Valid bits of the delay line; a reset drops every in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) ctl_valid <= '0;
    else       ctl_valid <= {ctl_valid[L-2:0], accept};
  end

  // Result register between the delay-line tail and the FIFO write port.
  always_ff @(posedge clk) begin
    if (reset) wr_valid <= 1'b0;
    else       wr_valid <= ctl_valid[L-1];
    wr_data <= tail_data;
  end

  // FIFO storage; a write after a reset is harmless since the pointers restart.
  always_ff @(posedge clk) begin
    if (wr_valid) mem[wr_ptr[PW-2:0]] <= wr_data;
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_valid) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Credit counter: in-flight plus buffered transactions.
  always_ff @(posedge clk) begin
    if (reset)                total <= '0;
    else if (accept && !pop)  total <= total + 1'b1;
    else if (!accept && pop)  total <= total - 1'b1;
  end

  assign out_valid = !reset && (wr_ptr != rd_ptr);
  assign out_data  = out_valid ? mem[rd_ptr[PW-2:0]] : '0;
  assign in_ready  = !reset && (total < PW'(FIFO_DEPTH));
  assign busy      = !reset && (total != '0);
endmodule

// File: tb/tb_act_deriv_pipe.sv
// Directed bench for act_deriv_pipe. It uses two instances, with FIFO
// depths 4 and 8. Both share the input stimulus; a select bit picks which
// instance is being checked.
// Expected lane values are worked out by hand from the derivative formulas.
module tb_act_deriv_pipe;
  localparam int DW = 128;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

`ifdef ACT_DERIV_LEAKY_EN
  localparam logic [31:0] ALPHA = 32'h3C23D70A;
`else
  localparam logic [31:0] ALPHA = 32'h00000000;
`endif

  logic          clk = 1'b0;
  logic          reset, in_valid, out_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_data;
  logic          in_ready4, out_valid4, busy4, in_ready8, out_valid8, busy8;
  logic [DW-1:0] out_data4, out_data8;
  logic          in_ready, out_valid, busy;
  logic [DW-1:0] out_data;
  bit            sel = 1'b0;
  int            cur_depth;

  vec_t          tbl [6];
  vec_t          in_q [$];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0, n_pass = 0;
  int            outstanding = 0, accepts = 0, pops = 0;

  // Clock and the instance select.
  always #5 clk = ~clk;
  assign in_ready  = sel ? in_ready8  : in_ready4;
  assign out_valid = sel ? out_valid8 : out_valid4;
  assign busy      = sel ? busy8      : busy4;
  assign out_data  = sel ? out_data8  : out_data4;
  assign cur_depth = sel ? 8 : 4;

  act_deriv_pipe #(.FIFO_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .busy(busy4));

  act_deriv_pipe dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid8),
    .out_ready(out_ready), .out_data(out_data8), .busy(busy8));

  function automatic vec_t mk(input logic [1:0] m, input logic [DW-1:0] d,
                              input logic [DW-1:0] e);
    vec_t v;
    v.mode = m;
    v.data = d;
    v.exp  = e;
    return v;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle. Drive the inputs, check in_ready against the credit
  // count, record the handshakes, then run the scoreboard after the edge.
  task automatic step(input bit vld_en, input bit rdy);
    bit            acc, pp;
    logic [DW-1:0] head;
    in_valid = vld_en && (in_q.size() != 0);
    if (in_valid) begin
      in_mode = in_q[0].mode;
      in_data = in_q[0].data;
    end
    out_ready = rdy;
    #1;
    check("in_ready", DW'(in_ready), DW'(!reset && (outstanding < cur_depth)));
    acc  = in_valid && in_ready;
    pp   = out_valid && out_ready;
    head = out_data;
    @(posedge clk);
    #1;
    if (reset) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      if (pp) begin
        pops++;
        outstanding--;
        check("out_expected", DW'(pp), DW'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("out_data", head, exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(in_q[0].exp);
        in_q.pop_front();
        outstanding++;
        accepts++;
      end
    end
  endtask

  initial begin
    int lat, cyc, stale;
    tbl[0] = mk(2'd0, {32'h40000000, 32'hBF800000, 32'h3F800000, 32'h00000000},
                      {32'h3D638E39, 32'h3E000000, 32'h3E000000, 32'h3F000000});
    tbl[1] = mk(2'd3, {4{32'h3F800000}}, {4{32'h3E800000}});
    tbl[2] = mk(2'd1, {32'h00000000, 32'h80000000, 32'hC0000000, 32'h40400000},
                      {32'h00000000, 32'h00000000, 32'h00000000, 32'h3F800000});
    tbl[3] = mk(2'd2, {32'h00000001, 32'h80000000, 32'h3F800000, 32'hC0000000},
                      {32'h3F800000, ALPHA, 32'h3F800000, ALPHA});
    tbl[4] = mk(2'd3, {32'hBF800000, 32'h40400000, 32'hC0000000, 32'h00000000},
                      {32'h3E800000, 32'h3D800000, 32'h3DE38E39, 32'h3F800000});
    tbl[5] = mk(2'd0, {32'h3F800000, 32'hC0400000, 32'h00000000, 32'h40400000},
                      {32'h3E000000, 32'h3D000000, 32'h3F000000, 32'h3D000000});

    // Reset values.
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'd0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_out_data", out_data, DW'(0));
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", DW'(in_ready), DW'(1));

    // Latency: one mode-0 transaction. out_valid rises 11 edges after acceptance.
    in_q.push_back(tbl[0]);
    step(1'b1, 1'b0);
    check("lat_accept", DW'(accepts), DW'(1));
    lat = 0;
    while (!out_valid && lat < 40) begin
      step(1'b0, 1'b0);
      lat++;
    end
    check("latency", DW'(lat), DW'(11));
    step(1'b0, 1'b1);
    check("lat_drained", DW'(outstanding), DW'(0));

    // Credit limit on depth 4, with back-to-back mixed modes.
    accepts = 0;
    for (int i = 1; i < 6; i++) in_q.push_back(tbl[i]);
    repeat (20) step(1'b1, 1'b0);
    check("fill_accepts", DW'(accepts), DW'(4));
    check("fill_in_ready", DW'(in_ready), DW'(0));
    check("fill_busy", DW'(busy), DW'(1));
    step(1'b1, 1'b1);
    check("pulse_pop", DW'(pops), DW'(2));
    check("pulse_in_ready", DW'(in_ready), DW'(1));
    cyc = 0;
    while ((outstanding != 0 || in_q.size() != 0) && cyc < 200) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    check("fill_drained", DW'(outstanding + in_q.size()), DW'(0));

    // Random valid/ready traffic drawn from the directed table.
    for (int i = 0; i < 300; i++) in_q.push_back(tbl[$urandom_range(0, 5)]);
    cyc = 0;
    while ((outstanding != 0 || in_q.size() != 0) && cyc < 6000) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      cyc++;
    end
    check("stress_drained", DW'(outstanding + in_q.size()), DW'(0));

    // Switch to depth 8 after a clean reset.
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    sel = 1'b1;
    #1;

    // Reset with 3 transactions in flight and 2 buffered.
    for (int i = 0; i < 5; i++) in_q.push_back(tbl[i]);
    repeat (5) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    check("pre_rst_outstanding", DW'(outstanding), DW'(5));
    check("pre_rst_out_valid", DW'(out_valid), DW'(1));
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("flush_out_valid", DW'(out_valid), DW'(0));
    check("flush_busy", DW'(busy), DW'(0));
    check("flush_in_ready", DW'(in_ready), DW'(1));
    stale = 0;
    repeat (30) begin
      if (out_valid) stale++;
      step(1'b0, 1'b1);
    end
    check("no_stale", DW'(stale), DW'(0));

    // Normal operation after the flush.
    in_q.push_back(tbl[3]);
    in_q.push_back(tbl[4]);
    cyc = 0;
    while ((outstanding != 0 || in_q.size() != 0) && cyc < 100) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    check("post_flush_drained", DW'(outstanding + in_q.size()), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
